// File: rtl/spi_master_xio.sv
// Single/dual/quad-lane SPI master with runtime CPOL/CPHA and lane mode.
// Chip-select stays asserted across a multi-word burst until a word marked last completes.
module spi_master_xio #(
  parameter int WORD_W            = 8,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int NUM_CS            = 1,
  parameter int CS_GAP            = 2,
  localparam int SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int CNT_W  = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1,
  localparam int GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1,
  localparam int EDGE_W = $clog2(2 * WORD_W + 1)
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Start,
  output logic              o_Ready,
  input  logic [WORD_W-1:0] i_TX_Word,
  input  logic              i_Dir,
  input  logic              i_Last,
  input  logic [1:0]        i_Mode,
  input  logic              i_CPOL,
  input  logic              i_CPHA,
  input  logic [SEL_W-1:0]  i_CS_Sel,
  output logic [WORD_W-1:0] o_RX_Word,
  output logic              o_RX_DV,
  output logic              o_Busy,
  output logic              o_SPI_Clk,
  output logic [NUM_CS-1:0] o_CS_N,
  output logic [3:0]        o_SIO_Out,
  output logic [3:0]        o_SIO_OE,
  input  logic [3:0]        i_SIO_In
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_HALF_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_M1  = GAP_W'(CS_GAP - 1);

  // Top L bits of a word placed on the lanes; lane L-1 carries the MSB.
  function automatic logic [3:0] lane_bits(input logic [WORD_W-1:0] w, input logic [1:0] m);
    case (m)
      2'd0:    lane_bits = {3'b000, w[WORD_W-1]};
      2'd1:    lane_bits = {2'b00, w[WORD_W-1 -: 2]};
      default: lane_bits = w[WORD_W-1 -: 4];
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] tx_shift(input logic [WORD_W-1:0] w, input logic [1:0] m);
    case (m)
      2'd0:    tx_shift = {w[WORD_W-2:0], 1'b0};
      2'd1:    tx_shift = {w[WORD_W-3:0], 2'b00};
      default: tx_shift = w << 3'd4;
    endcase
  endfunction

  // Single-lane receive uses lane 1 while lane 0 drives.
  function automatic logic [WORD_W-1:0] rx_shift(input logic [WORD_W-1:0] w, input logic [1:0] m,
                                                 input logic [3:0] sio);
    case (m)
      2'd0:    rx_shift = {w[WORD_W-2:0], sio[1]};
      2'd1:    rx_shift = {w[WORD_W-3:0], sio[1:0]};
      default: rx_shift = (w << 3'd4) | WORD_W'(sio);
    endcase
  endfunction

  function automatic logic [EDGE_W-1:0] edge_total(input logic [1:0] m);
    case (m)
      2'd0:    edge_total = EDGE_W'(2 * WORD_W);
      2'd1:    edge_total = EDGE_W'(WORD_W);
      default: edge_total = EDGE_W'(WORD_W / 2);
    endcase
  endfunction

  function automatic logic [3:0] oe_bits(input logic [1:0] m, input logic dir);
    if (m == 2'd0) begin
      oe_bits = 4'b0001;
    end else if (!dir) begin
      oe_bits = 4'b0000;
    end else if (m == 2'd1) begin
      oe_bits = 4'b0011;
    end else begin
      oe_bits = 4'b1111;
    end
  endfunction

  // An out-of-range select leaves every chip-select high.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [SEL_W-1:0] sel);
    cs_decode = {NUM_CS{1'b1}};
    for (int i = 0; i < NUM_CS; i++) begin
      cs_decode[i] = (sel != SEL_W'(i));
    end
  endfunction

  logic [2:0]        state_r;
  logic [1:0]        mode_r;
  logic              cpol_r;
  logic              cpha_r;
  logic              last_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [GAP_W-1:0]  gap_r;
  logic [EDGE_W-1:0] edge_r;
  logic [WORD_W-1:0] tx_sh_r;
  logic [WORD_W-1:0] rx_sh_r;
  logic [WORD_W-1:0] rx_word_r;
  logic              rx_pend_r;
  logic              rx_dv_r;
  logic              ready_r;
  logic              busy_r;
  logic              spi_clk_r;
  logic [NUM_CS-1:0] cs_n_r;
  logic [3:0]        sio_out_r;
  logic [3:0]        oe_r;

  logic              accept_s;
  logic              tick_s;
  logic              last_edge_s;
  logic              last_sample_s;
  logic              sample_s;
  logic              gap_done_s;
  logic [EDGE_W-1:0] edges_s;
  logic [1:0]        load_mode_s;
  logic              load_cpha_s;
  logic [WORD_W-1:0] tx_word_s;
  logic [2:0]        state_nx;

  // Handshake, edge bookkeeping and next-state selection.
  always_comb begin
    accept_s      = i_Start & ready_r;
    tick_s        = (cnt_r == {CNT_W{1'b0}});
    gap_done_s    = (gap_r == {GAP_W{1'b0}});
    edges_s       = edge_total(mode_r);
    last_edge_s   = (edge_r == edges_s - EDGE_W'(1));
    sample_s      = cpha_r ? edge_r[0] : ~edge_r[0];
    last_sample_s = cpha_r ? last_edge_s : (edge_r == edges_s - EDGE_W'(2));
    // Mid-burst words reuse the frozen mode and phase.
    load_mode_s   = (state_r == S_IDLE) ? i_Mode : mode_r;
    load_cpha_s   = (state_r == S_IDLE) ? i_CPHA : cpha_r;
    tx_word_s     = ((load_mode_s != 2'd0) && !i_Dir) ? {WORD_W{1'b0}} : i_TX_Word;
    state_nx      = state_r;
    case (state_r)
      S_IDLE:  if (accept_s) state_nx = S_SETUP; else state_nx = S_IDLE;
      S_SETUP: if (tick_s) state_nx = S_SHIFT; else state_nx = S_SETUP;
      S_SHIFT: begin
        if (tick_s && last_edge_s) begin
          state_nx = last_r ? S_HOLD : S_WAIT;
        end else begin
          state_nx = S_SHIFT;
        end
      end
      S_WAIT:  if (accept_s) state_nx = S_SHIFT; else state_nx = S_WAIT;
      S_HOLD:  if (tick_s) state_nx = S_GAP; else state_nx = S_HOLD;
      S_GAP:   if (gap_done_s) state_nx = S_IDLE; else state_nx = S_GAP;
      default: state_nx = S_IDLE;
    endcase
  end

  // Control state, serial clock generation and the shift datapath.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_r   <= S_IDLE;
      mode_r    <= 2'd0;
      cpol_r    <= 1'b0;
      cpha_r    <= 1'b0;
      last_r    <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      gap_r     <= {GAP_W{1'b0}};
      edge_r    <= {EDGE_W{1'b0}};
      tx_sh_r   <= {WORD_W{1'b0}};
      rx_sh_r   <= {WORD_W{1'b0}};
      rx_word_r <= {WORD_W{1'b0}};
      rx_pend_r <= 1'b0;
      rx_dv_r   <= 1'b0;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      spi_clk_r <= 1'b0;
      cs_n_r    <= {NUM_CS{1'b1}};
      sio_out_r <= 4'b0000;
      oe_r      <= 4'b0000;
    end else begin
      state_r   <= state_nx;
      ready_r   <= (state_nx == S_IDLE) || (state_nx == S_WAIT);
      busy_r    <= (state_nx != S_IDLE);
      rx_pend_r <= 1'b0;
      rx_dv_r   <= rx_pend_r;
      if (rx_pend_r) begin
        rx_word_r <= rx_sh_r;
      end
      if (accept_s) begin
        if (state_r == S_IDLE) begin
          mode_r    <= i_Mode;
          cpol_r    <= i_CPOL;
          cpha_r    <= i_CPHA;
          cs_n_r    <= cs_decode(i_CS_Sel);
          spi_clk_r <= i_CPOL;
        end
        last_r  <= i_Last;
        oe_r    <= oe_bits(load_mode_s, i_Dir);
        cnt_r   <= HALF_M1;
        edge_r  <= {EDGE_W{1'b0}};
        rx_sh_r <= {WORD_W{1'b0}};
        // With CPHA=0 the first bits must be on the lanes before the first leading edge.
        if (load_cpha_s) begin
          tx_sh_r <= tx_word_s;
        end else begin
          sio_out_r <= lane_bits(tx_word_s, load_mode_s);
          tx_sh_r   <= tx_shift(tx_word_s, load_mode_s);
        end
      end else begin
        case (state_r)
          S_SETUP: cnt_r <= tick_s ? HALF_M1 : cnt_r - CNT_W'(1);
          S_SHIFT: begin
            if (tick_s) begin
              cnt_r     <= HALF_M1;
              spi_clk_r <= ~spi_clk_r;
              edge_r    <= last_edge_s ? {EDGE_W{1'b0}} : edge_r + EDGE_W'(1);
              if (sample_s) begin
                rx_sh_r <= rx_shift(rx_sh_r, mode_r, i_SIO_In);
                if (last_sample_s) begin
                  rx_pend_r <= 1'b1;
                end
              end else begin
                sio_out_r <= lane_bits(tx_sh_r, mode_r);
                tx_sh_r   <= tx_shift(tx_sh_r, mode_r);
              end
            end else begin
              cnt_r <= cnt_r - CNT_W'(1);
            end
          end
          S_HOLD: begin
            if (tick_s) begin
              cs_n_r <= {NUM_CS{1'b1}};
              oe_r   <= 4'b0000;
              gap_r  <= GAP_M1;
            end else begin
              cnt_r <= cnt_r - CNT_W'(1);
            end
          end
          S_GAP: begin
            if (!gap_done_s) begin
              gap_r <= gap_r - GAP_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_Ready   = ready_r;
  assign o_Busy    = busy_r;
  assign o_RX_Word = rx_word_r;
  assign o_RX_DV   = rx_dv_r;
  assign o_SPI_Clk = spi_clk_r;
  assign o_CS_N    = cs_n_r;
  assign o_SIO_Out = sio_out_r;
  assign o_SIO_OE  = oe_r;

endmodule
